// File: rtl/cnf_stream_loader_if.sv
// Memory read-burst bus and literal load stream of the CNF loader.
// The loader is the master; the memory controller / solver array side is the slave.
interface cnf_stream_loader_if;
  logic        mem_read_req;
  logic [31:0] mem_read_addr;
  logic [7:0]  mem_read_len;
  logic        mem_read_grant;
  logic [31:0] mem_read_data;
  logic        mem_read_valid;

  logic        load_valid;
  logic [31:0] load_literal;
  logic        load_clause_end;
  logic        load_ready;

  modport master (
    output mem_read_req, mem_read_addr, mem_read_len,
    input  mem_read_grant, mem_read_data, mem_read_valid,
    output load_valid, load_literal, load_clause_end,
    input  load_ready
  );

  modport slave (
    input  mem_read_req, mem_read_addr, mem_read_len,
    output mem_read_grant, mem_read_data, mem_read_valid,
    input  load_valid, load_literal, load_clause_end,
    output load_ready
  );
endinterface

// File: rtl/cnf_stream_loader.sv
// Fetches a zero-terminated DIMACS literal image from memory in bursts and
// re-encodes it as a valid/ready literal stream with an in-band clause_end flag.
module cnf_stream_loader #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int AUTO_START = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [31:0] cfg_base_addr,
  input  logic [31:0] cfg_num_words,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] stat_clauses,
  output logic        solve_start,
  cnf_stream_loader_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   cur_addr, remaining;
  logic [7:0]    req_len, burst_len_q, beat_cnt;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_free, head;
  logic          fifo_empty, push, pop;
  logic          held_valid, held_valid_nxt;
  logic [31:0]   held_lit, held_lit_nxt;
  logic          start_accept, granted, last_beat, fetch_done, handshake, drained;

  assign fifo_empty   = (fifo_count == '0);
  assign head         = fifo_mem[rd_ptr];
  assign fifo_free    = 32'(FIFO_DEPTH) - 32'(fifo_count);
  assign req_len      = (remaining >= 32'(BURST_LEN)) ? 8'(BURST_LEN) : remaining[7:0];
  assign start_accept = cfg_start && (state == IDLE);

  // A burst is only requested once the FIFO can absorb all of it, so beats never stall.
  assign bus.mem_read_req  = (state == REQ) && (fifo_free >= 32'(req_len));
  assign bus.mem_read_addr = cur_addr;
  assign bus.mem_read_len  = req_len;
  assign granted           = bus.mem_read_req && bus.mem_read_grant;
  assign push              = (state == WAIT) && bus.mem_read_valid;
  assign last_beat         = push && (beat_cnt == burst_len_q - 8'd1);
  assign fetch_done        = (state == FLUSH);

  assign bus.load_valid      = held_valid && (!fifo_empty || fetch_done);
  assign bus.load_literal    = held_lit;
  assign bus.load_clause_end = bus.load_valid && (fifo_empty || head == '0);
  assign handshake           = bus.load_valid && bus.load_ready;

  assign busy        = (state == REQ) || (state == WAIT) || (state == FLUSH);
  assign done        = (state == DONE);
  assign solve_start = (AUTO_START != 0) && done;

  // Refill the held register when it is empty or being transferred; zeros only ever close a clause.
  always_comb begin
    pop            = 1'b0;
    held_valid_nxt = held_valid;
    held_lit_nxt   = held_lit;
    if (!held_valid || handshake) begin
      if (!fifo_empty) begin
        pop            = 1'b1;
        held_valid_nxt = (head != '0);
        held_lit_nxt   = head;
      end else begin
        held_valid_nxt = 1'b0;
      end
    end
  end

  assign drained = (fifo_empty || (fifo_count == CW'(1) && pop)) && !held_valid_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_accept) state_nxt = (cfg_num_words == '0) ? FLUSH : REQ;
      REQ:   if (granted) state_nxt = WAIT;
      WAIT:  if (last_beat) state_nxt = (remaining != '0) ? REQ : FLUSH;
      FLUSH: if (drained) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      burst_len_q  <= '0;
      beat_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      held_valid   <= 1'b0;
      held_lit     <= '0;
      error        <= 1'b0;
      stat_clauses <= '0;
    end else begin
      state <= state_nxt;
      if (start_accept) begin
        cur_addr     <= cfg_base_addr;
        remaining    <= cfg_num_words;
        stat_clauses <= '0;
        error        <= 1'b0;
      end
      if (granted) begin
        cur_addr    <= cur_addr + 32'(req_len);
        remaining   <= remaining - 32'(req_len);
        burst_len_q <= req_len;
        beat_cnt    <= '0;
      end
      if (push) beat_cnt <= beat_cnt + 8'd1;
      // Any beat the fetch FSM is not waiting for is a protocol error and is dropped.
      if (bus.mem_read_valid && state != WAIT) error <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      held_valid <= held_valid_nxt;
      held_lit   <= held_lit_nxt;
      if (handshake && bus.load_clause_end) stat_clauses <= stat_clauses + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_read_data;
  end
endmodule
